// File: rtl/temp_alarm_monitor.sv
// temp_alarm_monitor
//
// Consumer end of the temperature sensor interface. Accepted samples go into a
// power-of-two circular window whose running sum gives a moving average. A
// debounced threshold state machine with hysteresis watches that average and
// drives the alarm.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous active-high reset, overrides every other input
//   in_valid   temp holds a valid sample this cycle
//   temp       temperature sample
//   avg        registered moving average of the last 2^AVG_LOG2 samples
//   avg_valid  window has filled since reset (sticky until reset)
//   avg_upd    one-cycle pulse, avg was loaded at the previous edge
//   state      00 IDLE, 01 NORMAL, 10 PENDING, 11 ALARM
//   alarm      high exactly when state is ALARM
//   min_temp   (TEMP_STATS_EN only) smallest raw sample since reset
//   max_temp   (TEMP_STATS_EN only) largest raw sample since reset
//
// Optional feature macro: TEMP_STATS_EN adds the min_temp/max_temp outputs.

module temp_alarm_monitor #(
    parameter int WIDTH       = 8,
    parameter int AVG_LOG2    = 2,
    parameter int HIGH_THRESH = 200,
    parameter int LOW_THRESH  = 180,
    parameter int DEBOUNCE    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] temp,
    output logic [WIDTH-1:0] avg,
    output logic             avg_valid,
    output logic             avg_upd,
    output logic [1:0]       state,
`ifdef TEMP_STATS_EN
    output logic [WIDTH-1:0] min_temp,
    output logic [WIDTH-1:0] max_temp,
`endif
    output logic             alarm
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUMW  = WIDTH + AVG_LOG2;
    localparam logic [AVG_LOG2:0]  FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [AVG_LOG2:0]  FILL_LAST = (AVG_LOG2 + 1)'(DEPTH - 1);
    localparam logic [3:0]         DEB       = 4'(DEBOUNCE);
    localparam logic [WIDTH-1:0]   HI        = WIDTH'(HIGH_THRESH);
    localparam logic [WIDTH-1:0]   LO        = WIDTH'(LOW_THRESH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        NORMAL  = 2'b01,
        PENDING = 2'b10,
        ALARM   = 2'b11
    } state_t;

    logic [WIDTH-1:0]    buf_q [DEPTH];
    logic [WIDTH-1:0]    buf_d [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic [SUMW-1:0]     sum_q, sum_d, sum_next;
    logic [WIDTH-1:0]    avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                avg_upd_q, avg_upd_d;
    logic [3:0]          cnt_q, cnt_d;
    state_t              state_q, state_d;
    logic                alarm_q, alarm_d;
    logic                hot, cool;
`ifdef TEMP_STATS_EN
    logic [WIDTH-1:0]    min_q, min_d, max_q, max_d;
`endif

    // The oldest entry is always part of the sum, so subtracting it after the
    // add can never underflow and the result fits in WIDTH+AVG_LOG2 bits.
    assign sum_next = sum_q + SUMW'(temp) - SUMW'(buf_q[wr_ptr_q]);
    assign hot      = (avg_q >= HI);
    assign cool     = (avg_q <= LO);

    // Next-state logic for the window datapath and the threshold FSM. The FSM
    // only looks at avg on the cycle after it was reloaded, so each average is
    // judged exactly once.
    always_comb begin
        buf_d       = buf_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;
        avg_upd_d   = in_valid;
        cnt_d       = cnt_q;
        state_d     = state_q;
`ifdef TEMP_STATS_EN
        min_d       = min_q;
        max_d       = max_q;
`endif

        if (in_valid) begin
            buf_d[wr_ptr_q] = temp;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            sum_d           = sum_next;
            avg_d           = WIDTH'(sum_next >> AVG_LOG2);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
            if (fill_q == FILL_LAST) begin
                avg_valid_d = 1'b1;
            end
`ifdef TEMP_STATS_EN
            if (temp < min_q) min_d = temp;
            if (temp > max_q) max_d = temp;
`endif
        end

        if (avg_upd_q) begin
            case (state_q)
                // IDLE behaves like NORMAL as soon as the window is full, so
                // a window that fills already hot can go straight to PENDING.
                IDLE, NORMAL: begin
                    if (state_q == NORMAL || avg_valid_q) begin
                        if (hot) begin
                            cnt_d   = 4'd1;
                            state_d = (DEBOUNCE == 1) ? ALARM : PENDING;
                        end else begin
                            state_d = NORMAL;
                        end
                    end
                end
                PENDING: begin
                    if (hot) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d = ALARM;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = NORMAL;
                    end
                end
                // Hysteresis: only a clearly cool average drops the alarm.
                ALARM: begin
                    if (cool) begin
                        cnt_d   = 4'd0;
                        state_d = NORMAL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        alarm_d = (state_d == ALARM);
    end

    // All state in one register bank; reset wins over any sample in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            avg_upd_q   <= 1'b0;
            cnt_q       <= 4'd0;
            state_q     <= IDLE;
            alarm_q     <= 1'b0;
`ifdef TEMP_STATS_EN
            min_q       <= '1;
            max_q       <= '0;
`endif
        end else begin
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            avg_upd_q   <= avg_upd_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            alarm_q     <= alarm_d;
`ifdef TEMP_STATS_EN
            min_q       <= min_d;
            max_q       <= max_d;
`endif
        end
    end

    assign avg       = avg_q;
    assign avg_valid = avg_valid_q;
    assign avg_upd   = avg_upd_q;
    assign state     = state_q;
    assign alarm     = alarm_q;
`ifdef TEMP_STATS_EN
    assign min_temp  = min_q;
    assign max_temp  = max_q;
`endif

endmodule

// File: doc/temp_alarm_monitor.md
Name: temp_alarm_monitor

Overview:
Consumer end of the temperature sensor interface. Accepts 8-bit temperature samples, keeps a power-of-two moving average, and runs a debounced threshold state machine with hysteresis that drives an alarm. Sits downstream of the sensor model in the monitor top level; its outputs feed status and reporting logic.

Parameters:
WIDTH, 8, sample and average width in bits
AVG_LOG2, 2, log2 of averaging window depth (window = 4 samples)
HIGH_THRESH, 200, average at or above this value counts as "hot"
LOW_THRESH, 180, average at or below this value clears the alarm; must be < HIGH_THRESH
DEBOUNCE, 3, consecutive hot averages needed to raise the alarm; range 1..15

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous reset, active-high; has priority over all other inputs
in_valid  input  1  temp is a valid sample this cycle
temp  input  WIDTH  temperature sample
avg  output  WIDTH  registered moving average of the last 2^AVG_LOG2 accepted samples
avg_valid  output  1  window has filled since reset; sticky until reset
avg_upd  output  1  single-cycle pulse: avg was updated at the previous edge
state  output  2  FSM state: 00 IDLE, 01 NORMAL, 10 PENDING, 11 ALARM
alarm  output  1  high exactly when state == ALARM

Behaviour:
- Reset (synchronous): buffer entries = 0, sum = 0, avg = 0, fill count = 0, avg_valid = 0, avg_upd = 0, debounce count = 0, state = IDLE, alarm = 0.
- Sample accepted on a posedge with in_valid=1. With in_valid=0, no datapath or FSM state changes, and avg_upd is 0 the following cycle.
- Window: circular buffer of 2^AVG_LOG2 entries with a write pointer that wraps modulo depth. On accept, the new sample overwrites the oldest entry.
- Sum register is WIDTH+AVG_LOG2 bits wide and never overflows. Update rule: sum <= sum + temp - oldest.
- avg is loaded at the accept edge: avg <= (sum + temp - oldest) >> AVG_LOG2. The shift truncates (floor). Latency is 1 cycle from sample to avg.
- avg_upd <= in_valid each edge.
- Fill count saturates at 2^AVG_LOG2. avg_valid is set at the edge that accepts sample number 2^AVG_LOG2. Before that, avg is still computed, with empty slots reading as zero.
- FSM evaluates only on edges where avg_upd=1 (the cycle after an accept), using the current avg. Latency is 2 cycles from sample to state.
  - IDLE: stays IDLE while avg_valid=0. Once avg_valid=1, goes to NORMAL, or to PENDING/ALARM using the same rules as NORMAL.
  - NORMAL: if avg >= HIGH_THRESH, cnt <= 1 and go to PENDING. If DEBOUNCE == 1, go straight to ALARM instead. Otherwise stay in NORMAL.
  - PENDING: if avg >= HIGH_THRESH, cnt <= cnt+1; go to ALARM when cnt+1 == DEBOUNCE. If avg < HIGH_THRESH, go to NORMAL with cnt <= 0.
  - ALARM: stay while avg > LOW_THRESH. When avg <= LOW_THRESH, go to NORMAL with cnt <= 0. Averages between the thresholds do not clear the alarm (hysteresis).
- alarm is registered alongside state; there is no combinational path from temp.
- Boundaries:
  - avg == HIGH_THRESH counts as hot.
  - avg == LOW_THRESH clears the alarm.
  - Write-pointer wrap is seamless.
  - reset asserted together with in_valid: reset wins and the sample is dropped.
  - reset mid-window or while in ALARM: full reset; the next 2^AVG_LOG2 samples refill the window from zero.

Optional Feature:
TEMP_STATS_EN
- Defined: adds output ports min_temp [WIDTH] and max_temp [WIDTH], tracking the min and max of raw accepted samples since reset.
  - Reset values are min_temp = 2^WIDTH-1 and max_temp = 0.
  - Both update at the accept edge, so the first sample sets both.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 samples of 100 back-to-back -> avg_valid rises after 4th accept, avg=100, state IDLE->NORMAL two cycles after 4th sample, alarm=0.
- After fill, 6 samples of 220 -> avg 130,160,190,220,220,220; state PENDING on the 4th, ALARM on the 6th, alarm=1.
- From ALARM, samples of 150 -> avg 202,185,167; stays ALARM at 202 and 185, NORMAL at 167 (<=180).
- From PENDING with cnt=2, a sample drives avg to 199 -> state NORMAL, and the counter restarts: 3 fresh hot averages are needed for ALARM.
- Samples 1,1,1,2 with in_valid gaps between them -> avg=1 (truncated), no updates during gaps; then reset asserted simultaneously with in_valid -> avg=0, avg_valid=0, state IDLE.
- TEMP_STATS_EN defined, samples 50,7,255,90 -> min_temp=7, max_temp=255; after reset -> 255/0.
